present_round_key_gen: RTL and testbench
========================================

# present_round_key_gen

Sequential PRESENT-80 round-key generator. Accepts an 80-bit cipher key over a valid/ready handshake and iterates the PRESENT key-update step internally. Streams the 32 round keys K1..K32 (64 bits each) to the round datapath through a second valid/ready handshake. Sits between the key-load interface and the cipher round engine, which consumes one round key per round plus the final whitening key.

## Interface

**Parameters**
- `KEY_W`, 80: cipher key width. Fixed; only 80 is supported.
- `RK_W`, 64: round-key width, taken as key register bits [79:16].
- `NUM_RK`, 32: number of round keys emitted per key load (31 rounds plus final whitening).

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `key_in`, input, 80: cipher key, sampled on the key handshake.
- `key_valid`, input, 1: upstream has a key.
- `key_ready`, output, 1: block can accept a key. High only in IDLE.
- `rk_out`, output, 64: current round key.
- `rk_idx`, output, 5: index of `rk_out`. Runs 1..31, then 0 for K32.
- `rk_valid`, output, 1: `rk_out`/`rk_idx` valid.
- `rk_ready`, input, 1: downstream consumes the round key.
- `busy`, output, 1: high in EMIT.
- `done`, output, 1: one-cycle pulse after K32 is consumed.

## Operation

- **State** is `state` (IDLE/EMIT), `key_reg[79:0]` and `cnt[5:0]`.
- **Outputs from state:**
  - `rk_out = key_reg[79:16]`.
  - `rk_idx = cnt[4:0]`.
  - `rk_valid = busy = (state==EMIT)`.
  - `key_ready = (state==IDLE)`.
- **IDLE:** on `key_valid && key_ready`, load `key_reg <= key_in` and `cnt <= 1`, then go to EMIT.
- **EMIT, `rk_valid && rk_ready`, `cnt == 32`:** go to IDLE, pulse `done`, clear `cnt` to 0. `key_reg` holds its value.
- **EMIT, `rk_valid && rk_ready`, `cnt < 32`:** apply the key update with round counter `cnt[4:0]`, then `cnt <= cnt + 1`.
- **EMIT, `rk_ready` low:** everything holds; `rk_out` is stable while `rk_valid` is high.
- **Key update, in order** (input k, round counter i in 1..31):
  - Rotate left by 61: `k = {k[18:0], k[79:19]}`.
  - Substitute the top nibble: `k[79:76] = S(k[79:76])`.
  - XOR the counter: `k[19:15] ^= i[4:0]`, 5-bit XOR with no carry.
- **S-box**, input 0..F maps to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- **Index width:** the index is truncated to 5 bits, so K32 reports `rk_idx = 0`.
- **`key_valid` during EMIT:** ignored; `key_ready` is low and no key is captured.
- **`done`:** registered. It is high exactly the one cycle after the K32 handshake, the same cycle `key_ready` returns high.
- **Reset:** asynchronous and immediate, mid-operation included.
  - State goes to IDLE; `key_reg`, `cnt` and `done` clear to 0.
  - In-flight key sequence is discarded with no partial `done`.
  - Reset output values: `key_ready = 1`, `rk_valid = 0`, `busy = 0`, `done = 0`, `rk_out = 0`, `rk_idx = 0`.

## Timing

- **Load to K1:** key accepted at edge t, K1 valid in cycle t+1. Latency is 1 cycle.
- **Throughput:** one round key per cycle while `rk_ready` is held high. The update path is single-cycle combinational from `key_reg`.
- **Full sequence:** 32 cycles with no stall, from the first `rk_valid` to the last handshake.
- **Back-to-back keys:** earliest next key accept is the cycle `done` is high. IDLE lasts a minimum of 1 cycle.
- **Stall:** `rk_ready` low for N cycles extends the sequence by exactly N cycles with no skipped or duplicated index.
- **Output source:** all outputs are driven from registers or from simple decode of `state`/`cnt`. There is no combinational path from any input to any output.

## Test plan

- **Reset state:** assert `rst_n=0`, then release.
  - Required response: `key_ready=1`, `rk_valid=0`, `busy=0`, `done=0`, `rk_out=0`.
- **All-zero key, first two keys:** load `key_in=0`, hold `rk_ready=1`.
  - Cycle 1: K1 = 0x0000000000000000 with `rk_idx=1`.
  - Next cycle: K2 = 0xC000000000000000 with `rk_idx=2`.
  - Internal `key_reg` after the first update = 0xC0000000000000008000.
- **All-ones key, first two keys:** load `key_in=FFFF_FFFF_FFFF_FFFF_FFFF`.
  - K1 = 0xFFFFFFFFFFFFFFFF.
  - K2 = 0x2FFFFFFFFFFFFFFF.
  - `key_reg[15]` = 0 after the update.
- **Full sequence against a model:** compare all 32 keys with a reference model for the zero key and for key 0x0123456789ABCDEF0123.
  - `rk_idx` sequence must be 1..31 then 0.
  - `done` must pulse once, one cycle after K32.
  - Encrypting zero plaintext with the zero key using these keys must give 0x5579C1387B228445.
- **Random stalls and ignored input:** drive `rk_ready` with a random pattern and hold `key_valid=1` throughout EMIT.
  - `rk_out` must be stable during each stall and every key must match the model.
  - No key is captured until `done`, and the next key is accepted in the `done` cycle.
- **Reset mid-operation:** assert `rst_n=0` asynchronously at K10.
  - `rk_valid` drops without waiting for a clock edge and `done` never pulses.
  - After release, a new key produces the correct K1 with `rk_idx=1`.

Source files
------------

// File: rtl/present_round_key_gen_if.sv
// Key-load and round-key stream signals for the PRESENT-80 round-key generator.
// The slave modport is the generator's view; the master modport is the environment's view.
interface present_round_key_gen_if #(
  parameter int unsigned KEY_W = 80,
  parameter int unsigned RK_W  = 64
);
  logic [KEY_W-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic [RK_W-1:0]  rk_out;
  logic [4:0]       rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  key_in,
    input  key_valid,
    input  rk_ready,
    output key_ready,
    output rk_out,
    output rk_idx,
    output rk_valid,
    output busy,
    output done
  );

  modport master (
    output key_in,
    output key_valid,
    output rk_ready,
    input  key_ready,
    input  rk_out,
    input  rk_idx,
    input  rk_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/present_round_key_gen.sv
// Sequential PRESENT-80 round-key generator: loads an 80-bit key, then streams
// K1..K32 one per accepted handshake, updating the key register in place.
module present_round_key_gen #(
  parameter int unsigned KEY_W  = 80,
  parameter int unsigned RK_W   = 64,
  parameter int unsigned NUM_RK = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  present_round_key_gen_if.slave bus
);

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } state_e;

  state_e           r_state;
  logic [KEY_W-1:0] r_key;
  logic [5:0]       r_cnt;
  logic             r_done;

  logic [KEY_W-1:0] w_key_rot;
  logic [KEY_W-1:0] w_key_upd;
  logic             w_key_hs;
  logic             w_rk_hs;
  logic             w_last;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-schedule step: rotate left 61, S-box the top nibble, fold in the round counter.
  always_comb begin
    w_key_rot          = {r_key[18:0], r_key[KEY_W-1:19]};
    w_key_upd          = w_key_rot;
    w_key_upd[79:76]   = sbox(w_key_rot[79:76]);
    w_key_upd[19:15]   = w_key_rot[19:15] ^ r_cnt[4:0];
  end

  assign w_key_hs = bus.key_valid && (r_state == StIdle);
  assign w_rk_hs  = bus.rk_ready && (r_state == StEmit);
  assign w_last   = (r_cnt == 6'(NUM_RK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_key   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_key_hs) begin
            r_key   <= bus.key_in;
            r_cnt   <= 6'd1;
            r_state <= StEmit;
          end
        end
        StEmit: begin
          if (w_rk_hs) begin
            if (w_last) begin
              // Key register keeps K32's source; only the counter resets.
              r_state <= StIdle;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_key <= w_key_upd;
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rk_out    = r_key[KEY_W-1:KEY_W-RK_W];
  assign bus.rk_idx    = r_cnt[4:0];
  assign bus.rk_valid  = (r_state == StEmit);
  assign bus.busy      = (r_state == StEmit);
  assign bus.key_ready = (r_state == StIdle);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_present_round_key_gen.sv
// Randomised self-checking bench for present_round_key_gen against an arithmetic key-schedule model.
module tb_present_round_key_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  present_round_key_gen_if bus ();

  present_round_key_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_pulses = 0;
  int seqs_done = 0;

  logic [3:0]  sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] model_rk [1:32];
  logic [63:0] obs_rk   [1:32];

  always @(negedge clk) if (bus.done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] rand_key();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[79:0];
  endfunction

  // Key schedule as plain arithmetic on an 80-bit number.
  task automatic model_keys(input logic [79:0] key);
    logic [79:0] k;
    int          nib;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      model_rk[r] = 64'(k >> 16);
      k   = (k << 61) | (k >> 19);
      nib = int'(k >> 76);
      k   = (k & ~(80'hF << 76)) | (80'(sbox_tab[nib]) << 76);
      k   = k ^ (80'(r) << 15);
    end
  endtask

  function automatic logic [63:0] present_enc(input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] t;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ obs_rk[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_tab[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 63; b++) t[(16 * b) % 63] = s[b];
      t[63] = s[63];
      s = t;
    end
    return s ^ obs_rk[32];
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge after acceptance.
  task automatic load_key(input logic [79:0] k);
    check("load_key_ready", 80'(bus.key_ready), 80'(1));
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic emit_seq(input logic [79:0] key, input bit stall, input bit hold_valid);
    int          idx = 1;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [63:0] prev = '0;
    model_keys(key);
    while (idx <= 32 && cyc < 2000) begin
      check("rk_valid", 80'(bus.rk_valid), 80'(1));
      check("busy", 80'(bus.busy), 80'(1));
      check("key_ready_emit", 80'(bus.key_ready), 80'(0));
      check("done_emit", 80'(bus.done), 80'(0));
      check("rk_out", 80'(bus.rk_out), 80'(model_rk[idx]));
      check("rk_idx", 80'(bus.rk_idx), 80'(idx % 32));
      if (stalled) check("stall_hold", 80'(bus.rk_out), 80'(prev));
      obs_rk[idx] = bus.rk_out;
      prev = bus.rk_out;
      bus.rk_ready = stall ? ($urandom_range(0, 99) < 60) : 1'b1;
      if (hold_valid) begin
        bus.key_valid = 1'b1;
        bus.key_in    = rand_key();
      end
      stalled = !bus.rk_ready;
      if (bus.rk_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    if (idx <= 32) check("seq_timeout", 80'(idx), 80'(33));
    else seqs_done++;
    bus.rk_ready  = 1'b0;
    bus.key_valid = 1'b0;
    check("done_pulse", 80'(bus.done), 80'(1));
    check("key_ready_done", 80'(bus.key_ready), 80'(1));
    check("rk_valid_done", 80'(bus.rk_valid), 80'(0));
  endtask

  initial begin
    logic [79:0] k;
    int          snap;
    int          cyc;
    bus.key_in    = '0;
    bus.key_valid = 1'b0;
    bus.rk_ready  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_key_ready", 80'(bus.key_ready), 80'(1));
    check("rst_rk_valid", 80'(bus.rk_valid), 80'(0));
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_done", 80'(bus.done), 80'(0));
    check("rst_rk_out", 80'(bus.rk_out), 80'(0));
    check("rst_rk_idx", 80'(bus.rk_idx), 80'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_key_ready", 80'(bus.key_ready), 80'(1));

    // All-zero key, full sequence, then encrypt zero plaintext with the observed keys.
    load_key('0);
    emit_seq('0, 1'b0, 1'b0);
    check("zero_K1", 80'(obs_rk[1]), 80'(64'h0));
    check("zero_K2", 80'(obs_rk[2]), 80'(64'hC000_0000_0000_0000));
    check("present_enc", 80'(present_enc(64'h0)), 80'(64'h5579_C138_7B22_8445));
    @(negedge clk);
    check("done_once", 80'(bus.done), 80'(0));

    load_key({80{1'b1}});
    emit_seq({80{1'b1}}, 1'b0, 1'b0);
    check("ones_K1", 80'(obs_rk[1]), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    check("ones_K2", 80'(obs_rk[2]), 80'(64'h2FFF_FFFF_FFFF_FFFF));

    // Back-to-back: next key offered in the done cycle.
    load_key(80'h0123_4567_89AB_CDEF_0123);
    emit_seq(80'h0123_4567_89AB_CDEF_0123, 1'b0, 1'b0);

    // Random stalls with key_valid held through EMIT, chained back-to-back.
    for (int i = 0; i < 4; i++) begin
      k = rand_key();
      load_key(k);
      emit_seq(k, 1'b1, 1'b1);
    end

    // Asynchronous reset at K10.
    k = rand_key();
    load_key(k);
    bus.rk_ready = 1'b1;
    cyc = 0;
    while (bus.rk_idx != 5'd10 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_K10", 80'(bus.rk_idx), 80'(10));
    snap = done_pulses;
    #2 rst_n = 1'b0;
    #1;
    check("async_rk_valid", 80'(bus.rk_valid), 80'(0));
    check("async_busy", 80'(bus.busy), 80'(0));
    check("async_key_ready", 80'(bus.key_ready), 80'(1));
    check("async_rk_out", 80'(bus.rk_out), 80'(0));
    check("async_rk_idx", 80'(bus.rk_idx), 80'(0));
    check("async_done", 80'(bus.done), 80'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("no_partial_done", 80'(done_pulses), 80'(snap));
    k = rand_key();
    load_key(k);
    emit_seq(k, 1'b1, 1'b0);

    @(negedge clk);
    check("done_count", 80'(done_pulses), 80'(seqs_done));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
